// File: rtl/galvani_trig_router.sv
// rtl/galvani_trig_router.sv - stim trigger edge detect, NI pulse stretcher and per-frame capture
//
// Purpose:
//   Rising edges on the per-channel stim trigger levels are masked and merged
//   into one retriggerable, stretched pulse for the NI digital input. Every
//   rising edge (masked or not) is also accumulated into a sticky vector that
//   is snapshotted and cleared on each recorder frame sync.
//
// Optional feature:
//   GALVANI_TRIG_CNT_EN - when defined, a saturating 16-bit counter of masked
//   hit cycles per frame is reported on evt_cnt; otherwise evt_cnt is 16'h0000.
//
// Ports:
//   CLK          system clock
//   RST          asynchronous active-high reset
//   trig_in      per-channel trigger levels from the stim engine
//   cfg_wr       one-cycle strobe loading cfg_mask and cfg_stretch
//   cfg_mask     channel enable mask for the NI output and event count
//   cfg_stretch  NI pulse length in CLK cycles (0 disables the NI output)
//   frame_sync   one-cycle frame boundary pulse from the recorder
//   trig_ni      stretched merged trigger to NI
//   trig_frame   channels that rose during the last closed frame
//   frame_valid  one-cycle strobe: trig_frame / evt_cnt updated
//   evt_cnt      masked event cycles in the last closed frame

module galvani_trig_router #(
   parameter int                       NUM_CH          = 128,
   parameter int                       STRETCH_W       = 8,
   parameter logic [STRETCH_W-1:0]     DEFAULT_STRETCH = 8'd10
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NUM_CH-1:0]    trig_in,
   input  logic                 cfg_wr,
   input  logic [NUM_CH-1:0]    cfg_mask,
   input  logic [STRETCH_W-1:0] cfg_stretch,
   input  logic                 frame_sync,
   output logic                 trig_ni,
   output logic [NUM_CH-1:0]    trig_frame,
   output logic                 frame_valid,
   output logic [15:0]          evt_cnt
);

   logic [NUM_CH-1:0]    trig_q;
   logic [NUM_CH-1:0]    mask;
   logic [NUM_CH-1:0]    sticky;
   logic [NUM_CH-1:0]    rise;
   logic [STRETCH_W-1:0] stretch;
   logic [STRETCH_W-1:0] cnt;
   logic [STRETCH_W-1:0] cnt_nxt;
   logic                 hit;

   // Falling edges are deliberately ignored.
   assign rise = trig_in & ~trig_q;
   assign hit  = |(rise & mask);

   // A hit always reloads, so a later hit extends (or, after a stretch change,
   // reshapes) the pulse. A cfg_wr alone never touches the running count.
   always_comb begin
      cnt_nxt = cnt;
      if (hit) begin
         cnt_nxt = stretch;
      end else if (cnt != '0) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         trig_q      <= '0;
         mask        <= '1;
         stretch     <= DEFAULT_STRETCH;
         cnt         <= '0;
         trig_ni     <= 1'b0;
         sticky      <= '0;
         trig_frame  <= '0;
         frame_valid <= 1'b0;
      end else begin
         trig_q  <= trig_in;
         cnt     <= cnt_nxt;
         // Registered from the next count so the pulse starts the cycle after
         // the edge and lasts exactly 'stretch' cycles.
         trig_ni <= (cnt_nxt != '0);

         // Edges coincident with frame_sync belong to the frame being closed.
         if (frame_sync) begin
            trig_frame  <= sticky | rise;
            sticky      <= '0;
            frame_valid <= 1'b1;
         end else begin
            sticky      <= sticky | rise;
            frame_valid <= 1'b0;
         end

         // Registered config: edges seen in the cfg_wr cycle use old values.
         if (cfg_wr) begin
            mask    <= cfg_mask;
            stretch <= cfg_stretch;
         end
      end
   end

`ifdef GALVANI_TRIG_CNT_EN
   logic [15:0] ev_acc;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ev_acc  <= '0;
         evt_cnt <= '0;
      end else if (frame_sync) begin
         // The hit in the closing cycle is counted into the closing frame.
         if (hit && (ev_acc != 16'hFFFF)) begin
            evt_cnt <= ev_acc + 16'd1;
         end else begin
            evt_cnt <= ev_acc;
         end
         ev_acc <= '0;
      end else if (hit && (ev_acc != 16'hFFFF)) begin
         ev_acc <= ev_acc + 16'd1;
      end
   end
`else
   assign evt_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_galvani_trig_router.sv
// tb/tb_galvani_trig_router.sv - self-checking bench for galvani_trig_router

module tb_galvani_trig_router;

   localparam int N = 128;

   logic          CLK = 1'b0;
   logic          RST;
   logic [N-1:0]  trig_in;
   logic          cfg_wr;
   logic [N-1:0]  cfg_mask;
   logic [7:0]    cfg_stretch;
   logic          frame_sync;
   logic          trig_ni;
   logic [N-1:0]  trig_frame;
   logic          frame_valid;
   logic [15:0]   evt_cnt;

   int vectors     = 0;
   int miscompares = 0;

   galvani_trig_router #(
      .NUM_CH(N),
      .STRETCH_W(8),
      .DEFAULT_STRETCH(8'd10)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .trig_in(trig_in),
      .cfg_wr(cfg_wr),
      .cfg_mask(cfg_mask),
      .cfg_stretch(cfg_stretch),
      .frame_sync(frame_sync),
      .trig_ni(trig_ni),
      .trig_frame(trig_frame),
      .frame_valid(frame_valid),
      .evt_cnt(evt_cnt)
   );

   always #5 CLK = ~CLK;

   // Reference model: time-based view of the pulse (last hit time and the
   // stretch in force at that hit) and set-based view of frame contents.
   logic [N-1:0]  m_prev, m_mask, m_sticky, m_frame;
   logic [7:0]    m_stretch;
   logic          m_fv;
   logic [15:0]   m_evt;
   int            m_cyc, m_last_hit, m_last_s, m_count;

   function automatic logic m_ni(input int cyc, input int last_hit, input int last_s);
      return ((cyc - last_hit) >= 1) && ((cyc - last_hit) <= last_s);
   endfunction

   task automatic model_reset();
      m_prev     = '0;
      m_mask     = '1;
      m_stretch  = 8'd10;
      m_last_hit = -1000000;
      m_last_s   = 0;
      m_sticky   = '0;
      m_frame    = '0;
      m_fv       = 1'b0;
      m_count    = 0;
      m_evt      = 16'h0000;
   endtask

   // Advance the model with the inputs presented this cycle, then clock the
   // DUT and return 1 time unit after the edge.
   task automatic tick();
      logic [N-1:0] rise;
      logic         hit;
      int           total;
      rise = trig_in & ~m_prev;
      hit  = |(rise & m_mask);
      if (hit) begin
         m_last_hit = m_cyc;
         m_last_s   = int'(m_stretch);
      end
      if (frame_sync) begin
         m_frame  = m_sticky | rise;
         m_sticky = '0;
         total    = m_count + int'(hit);
`ifdef GALVANI_TRIG_CNT_EN
         m_evt    = (total > 65535) ? 16'hFFFF : 16'(total);
`else
         m_evt    = 16'h0000;
`endif
         m_count  = 0;
         m_fv     = 1'b1;
      end else begin
         m_sticky = m_sticky | rise;
         m_count  = m_count + int'(hit);
         m_fv     = 1'b0;
      end
      if (cfg_wr) begin
         m_mask    = cfg_mask;
         m_stretch = cfg_stretch;
      end
      m_prev = trig_in;
      @(posedge CLK);
      m_cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #1;
      vectors++;
      if ({trig_ni, frame_valid, trig_frame, evt_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ni=%b fv=%b frame=%h evt=%h required all zero",
                  trig_ni, frame_valid, trig_frame, evt_cnt);
      end
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      m_cyc = 0;
   endtask

   task automatic test_single_pulse();
      int highs;
      idle(9);
      trig_in[5] = 1'b1;
      tick();
      highs = 0;
      for (int k = 0; k < 14; k++) begin
         vectors++;
         if (trig_ni !== (k < 10)) begin
            miscompares++;
            $display("FAIL single_pulse k=%0d: got %b required %b", k, trig_ni, (k < 10));
         end
         if (trig_ni === 1'b1) highs++;
         tick();
      end
      vectors++;
      if (highs != 10) begin
         miscompares++;
         $display("FAIL single_pulse_len: got %0d required 10", highs);
      end
      trig_in = '0;
   endtask

   task automatic test_mask();
      idle(12);
      cfg_mask    = '0;
      cfg_mask[3] = 1'b1;
      cfg_stretch = 8'd4;
      cfg_wr      = 1'b1;
      tick();
      cfg_wr = 1'b0;
      trig_in[7] = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (trig_ni !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_ch7 k=%0d: got %b required 0", k, trig_ni);
         end
         tick();
      end
      trig_in[3] = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         vectors++;
         if (trig_ni !== (k < 4)) begin
            miscompares++;
            $display("FAIL mask_ch3 k=%0d: got %b required %b", k, trig_ni, (k < 4));
         end
         tick();
      end
      trig_in = '0;
   endtask

   task automatic test_retrigger();
      cfg_mask    = '1;
      cfg_stretch = 8'd5;
      cfg_wr      = 1'b1;
      tick();
      cfg_wr = 1'b0;
      idle(8);
      for (int j = 0; j < 10; j++) begin
         trig_in[0] = (j == 0) || (j == 2);
         tick();
         vectors++;
         if (trig_ni !== (j <= 6)) begin
            miscompares++;
            $display("FAIL retrigger j=%0d: got %b required %b", j, trig_ni, (j <= 6));
         end
      end
      trig_in = '0;
   endtask

   task automatic test_frame();
      logic [N-1:0] exp_v;
      idle(2);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      trig_in[1] = 1'b1;
      tick();
      trig_in[100] = 1'b1;
      tick();
      trig_in[2] = 1'b1;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      exp_v = '0;
      exp_v[1] = 1'b1;
      exp_v[2] = 1'b1;
      exp_v[100] = 1'b1;
      vectors++;
      if (trig_frame !== exp_v || frame_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_capture: got frame=%h fv=%b required frame=%h fv=1",
                  trig_frame, frame_valid, exp_v);
      end
      vectors++;
      if (evt_cnt !== m_evt) begin
         miscompares++;
         $display("FAIL frame_evt: got %h required %h", evt_cnt, m_evt);
      end
      tick();
      vectors++;
      if (frame_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_valid_drop: got %b required 0", frame_valid);
      end
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (trig_frame !== '0 || evt_cnt !== 16'h0000 || frame_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_frame: got frame=%h evt=%h fv=%b required 0/0000/1",
                  trig_frame, evt_cnt, frame_valid);
      end
      trig_in = '0;
   endtask

   task automatic test_evt_cnt();
      logic [15:0] exp_sat, exp_three;
`ifdef GALVANI_TRIG_CNT_EN
      exp_sat   = 16'hFFFF;
      exp_three = 16'd3;
`else
      exp_sat   = 16'h0000;
      exp_three = 16'h0000;
`endif
      trig_in = '0;
      idle(3);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         trig_in[0] = (i % 2 == 0);
         trig_in[1] = (i % 2 == 1);
         tick();
      end
      trig_in    = '0;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (evt_cnt !== exp_sat || evt_cnt !== m_evt) begin
         miscompares++;
         $display("FAIL evt_saturate: got %h required %h", evt_cnt, exp_sat);
      end
      for (int i = 0; i < 6; i++) begin
         trig_in[0] = (i % 2 == 0);
         tick();
      end
      trig_in    = '0;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      vectors++;
      if (evt_cnt !== exp_three || evt_cnt !== m_evt) begin
         miscompares++;
         $display("FAIL evt_three: got %h required %h", evt_cnt, exp_three);
      end
   endtask

   task automatic test_random();
      int idx;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            idx = int'($urandom_range(0, N - 1));
            trig_in[idx] = ~trig_in[idx];
         end
         if ($urandom_range(0, 3) == 0) begin
            idx = int'($urandom_range(0, 15));
            trig_in[idx] = ~trig_in[idx];
         end
         cfg_wr = ($urandom_range(0, 24) == 0);
         if (cfg_wr) begin
            if ($urandom_range(0, 1) == 0) begin
               cfg_mask = '1;
            end else begin
               cfg_mask = '0;
               for (int b = 0; b < 8; b++) cfg_mask[$urandom_range(0, 15)] = 1'b1;
            end
            cfg_stretch = 8'($urandom_range(0, 12));
         end
         frame_sync = ($urandom_range(0, 9) == 0);
         tick();
         cfg_wr     = 1'b0;
         frame_sync = 1'b0;
         vectors++;
         if (trig_ni !== m_ni(m_cyc, m_last_hit, m_last_s)) begin
            miscompares++;
            $display("FAIL rand_ni c=%0d: got %b required %b", c, trig_ni,
                     m_ni(m_cyc, m_last_hit, m_last_s));
         end
         vectors++;
         if (frame_valid !== m_fv) begin
            miscompares++;
            $display("FAIL rand_fv c=%0d: got %b required %b", c, frame_valid, m_fv);
         end
         vectors++;
         if (trig_frame !== m_frame) begin
            miscompares++;
            $display("FAIL rand_frame c=%0d: got %h required %h", c, trig_frame, m_frame);
         end
         vectors++;
         if (evt_cnt !== m_evt) begin
            miscompares++;
            $display("FAIL rand_evt c=%0d: got %h required %h", c, evt_cnt, m_evt);
         end
      end
      trig_in = '0;
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] exp_v;
      cfg_mask    = '1;
      cfg_stretch = 8'd10;
      cfg_wr      = 1'b1;
      tick();
      cfg_wr = 1'b0;
      idle(12);
      trig_in[30] = 1'b1;
      tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      trig_in[20] = 1'b1;
      tick();
      tick();
      vectors++;
      if (trig_ni !== 1'b1 || trig_frame !== m_frame) begin
         miscompares++;
         $display("FAIL pre_reset_state: got ni=%b frame=%h required ni=1 frame=%h",
                  trig_ni, trig_frame, m_frame);
      end
      trig_in[9] = 1'b1;
      RST = 1'b1;
      #1;
      vectors++;
      if ({trig_ni, frame_valid, trig_frame, evt_cnt} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got ni=%b fv=%b frame=%h evt=%h required all zero",
                  trig_ni, frame_valid, trig_frame, evt_cnt);
      end
      trig_in[20] = 1'b0;
      trig_in[30] = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      tick();
      vectors++;
      if (trig_ni !== 1'b1) begin
         miscompares++;
         $display("FAIL held_edge_after_reset: got %b required 1", trig_ni);
      end
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      exp_v = '0;
      exp_v[9] = 1'b1;
      vectors++;
      if (trig_frame !== exp_v) begin
         miscompares++;
         $display("FAIL post_reset_sticky: got %h required %h", trig_frame, exp_v);
      end
      trig_in = '0;
   endtask

   initial begin
      trig_in     = '0;
      cfg_wr      = 1'b0;
      cfg_mask    = '0;
      cfg_stretch = 8'd0;
      frame_sync  = 1'b0;
      m_cyc       = 0;
      model_reset();
      test_reset();
      test_single_pulse();
      test_mask();
      test_retrigger();
      test_frame();
      test_evt_cnt();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/galvani_trig_router.md
# galvani_trig_router

Parametrised trigger router between the stimulation engine and the recording AFE. It replaces the fixed 128-bit trigger bus and single NI trigger line. Per-channel stim trigger levels are edge-detected and masked, merged into one retriggerable, stretched pulse for the NI digital input, and accumulated into a per-frame sticky vector. That vector is snapshotted on every recording frame sync so trigger events can be aligned with sample frames.

## Interface
Parameters:
- NUM_CH, 128, number of stim trigger channels (1..256)
- STRETCH_W, 8, width of stretch length register
- DEFAULT_STRETCH, 8'd10, reset value of stretch length (cycles)

Ports:
- CLK  in  1  system clock; all inputs synchronous to it
- RST  in  1  asynchronous, active-high reset
- trig_in  in  NUM_CH  per-channel trigger levels from stim engine
- cfg_wr  in  1  one-cycle strobe: load cfg_mask and cfg_stretch
- cfg_mask  in  NUM_CH  channel enable mask for NI output/count
- cfg_stretch  in  STRETCH_W  NI pulse length in CLK cycles
- frame_sync  in  1  one-cycle pulse from recorder at frame boundary
- trig_ni  out  1  stretched merged trigger to NI
- trig_frame  out  NUM_CH  channels that rose during the last closed frame
- frame_valid  out  1  one-cycle strobe: trig_frame/evt_cnt updated
- evt_cnt  out  16  masked event cycles in last closed frame

## Operation
- Edge detect: trig_q <= trig_in each cycle; edge = trig_in & ~trig_q. Falling edges are ignored.
- Masked hit: hit = |(edge & mask).
- Stretch counter cnt (STRETCH_W bits):
  - On hit: cnt <= stretch. A hit reloads even while counting (retrigger).
  - Otherwise, if cnt != 0: cnt <= cnt-1.
  - trig_ni is registered: trig_ni <= (next cnt != 0).
  - stretch == 0 disables trig_ni entirely.
- Sticky accumulator sticky[NUM_CH] records every edge regardless of mask: sticky <= sticky | edge.
- On frame_sync:
  - trig_frame <= sticky | edge. Edges coincident with frame_sync belong to the closing frame.
  - sticky <= 0.
  - frame_valid <= 1 for exactly one cycle.
- Config: on cfg_wr, mask <= cfg_mask and stretch <= cfg_stretch. Edges sampled in the cfg_wr cycle use the old values.
- A cfg_wr during an active pulse does not truncate or reload cnt. The new stretch applies from the next hit.
- Reset values:
  - mask = all ones, stretch = DEFAULT_STRETCH.
  - trig_q = 0, cnt = 0, sticky = 0.
  - trig_ni = 0, trig_frame = 0, frame_valid = 0, evt_cnt = 0.
- Reset mid-pulse clears trig_ni asynchronously.
- trig_q resets to 0, so a trig_in held high through reset release produces an edge on the first clock after release.

## Timing
- Rising trig_in sampled at edge t: trig_ni is high from t+1 through t+stretch (stretch cycles).
- Hit at t and again at t+k (k < stretch): trig_ni is high continuously from t+1 through t+k+stretch.
- frame_sync sampled at t: trig_frame, evt_cnt and frame_valid are valid at t+1. frame_valid is low again at t+2.
- frame_sync on consecutive cycles: each cycle closes a frame. An empty frame yields trig_frame = 0 and evt_cnt = 0.
- Throughput: one trig_in vector per cycle, no stalls, no backpressure.

## Configuration
- GALVANI_TRIG_CNT_EN defined:
  - A 16-bit frame counter increments on every cycle with hit and saturates at 16'hFFFF.
  - On frame_sync: evt_cnt <= counter + hit (saturating), then counter <= 0.
- Not defined:
  - The counter logic is absent and evt_cnt is constant 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset, then trig_in[5] rises at cycle 10 with default stretch 10 → trig_ni high for cycles 11–20 exactly; low at 21.
- cfg_wr with mask = only ch3 and stretch = 4; pulse ch7, then ch3 → no trig_ni for ch7; trig_ni high 4 cycles after ch3.
- Hits on ch0 at t and t+2 with stretch 5 → trig_ni continuous from t+1 through t+7.
- Edges on ch1 and ch100, frame_sync asserted in the same cycle as a ch2 edge → next cycle trig_frame has bits 1, 2 and 100 set and frame_valid = 1. A following frame_sync with no edges → trig_frame = 0.
- With GALVANI_TRIG_CNT_EN:
  - 70000 hit cycles in one frame → evt_cnt = 16'hFFFF.
  - The next frame has 3 hits → evt_cnt = 3.
  - Without the macro, evt_cnt = 0 throughout.
- Assert RST mid-pulse and mid-frame → all outputs return to 0 immediately. After release, the sticky vector contains no pre-reset edges.
